// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// md_unit_if : EX-stage request bus and HI/LO result view for md_unit
// Revision   : 1.0
// ============================================================================
interface md_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_val, rt_val,
      input  busy, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val,
      output busy, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// md_unit  : multi-cycle multiply/divide unit with HI/LO registers (EX stage)
// Revision : 1.0
// ============================================================================
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  wire logic clk,
   input  wire logic reset,
   md_unit_if.slave  bus
);
   localparam logic [0:0] c_idle      = 1'b0;
   localparam logic [0:0] c_run       = 1'b1;
   localparam logic [2:0] c_op_mult   = 3'd0;
   localparam logic [2:0] c_op_multu  = 3'd1;
   localparam logic [2:0] c_op_div    = 3'd2;
   localparam logic [2:0] c_op_divu   = 3'd3;
   localparam logic [2:0] c_op_mthi   = 3'd4;
   localparam logic [2:0] c_op_mtlo   = 3'd5;
   localparam logic [3:0] c_mult_load = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] c_div_load  = 4'(DIV_CYCLES - 1);

   logic [0:0]  r_state;
   logic [0:0]  w_state_next;
   logic [3:0]  r_cnt;
   logic [2:0]  r_op;
   logic [31:0] r_rs;
   logic [31:0] r_rt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        w_busy;

   logic        w_accept;
   logic        w_done;
   logic        w_is_div;
   logic        w_div_zero;

   assign w_accept   = (r_state == c_idle) && bus.start && (bus.op[2] == 1'b0);
   assign w_done     = (r_state == c_run) && (r_cnt == 4'd0);
   assign w_is_div   = (r_op == c_op_div) || (r_op == c_op_divu);
   assign w_div_zero = w_is_div && (r_rt == 32'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_idle:  if (w_accept) w_state_next = c_run;
         c_run:   if (w_done)   w_state_next = c_idle;
         default: w_state_next = c_idle;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      if (r_state == c_run) w_busy = 1'b1;
   end

   assign bus.busy = w_busy;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= 4'd0;
         r_op  <= 3'd0;
         r_rs  <= 32'd0;
         r_rt  <= 32'd0;
      end else if (w_accept) begin
         r_op  <= bus.op;
         r_rs  <= bus.rs_val;
         r_rt  <= bus.rt_val;
         r_cnt <= bus.op[1] ? c_div_load : c_mult_load;
      end else if ((r_state == c_run) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Result is formed combinationally from the latched operands and only
   // committed on the final RUN edge, so HI/LO never move early.
   logic        w_signed_op;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [63:0] w_a_ext;
   logic [63:0] w_b_ext;
   logic [63:0] w_prod;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_den;
   logic [31:0] w_uquot;
   logic [31:0] w_urem;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;

   always_comb begin
      w_signed_op = (r_op == c_op_mult) || (r_op == c_op_div);
      w_a_neg     = w_signed_op & r_rs[31];
      w_b_neg     = w_signed_op & r_rt[31];
      w_a_ext     = {{32{w_a_neg}}, r_rs};
      w_b_ext     = {{32{w_b_neg}}, r_rt};
      w_prod      = w_a_ext * w_b_ext;
      // Sign-magnitude divide keeps 0x80000000 / -1 well defined.
      w_a_mag     = w_a_neg ? (32'd0 - r_rs) : r_rs;
      w_b_mag     = w_b_neg ? (32'd0 - r_rt) : r_rt;
      w_den       = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
      w_uquot     = w_a_mag / w_den;
      w_urem      = w_a_mag % w_den;
      w_quot      = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uquot) : w_uquot;
      w_rem       = w_a_neg ? (32'd0 - w_urem) : w_urem;
      if (w_is_div) begin
         w_res_hi = w_rem;
         w_res_lo = w_quot;
      end else begin
         w_res_hi = w_prod[63:32];
         w_res_lo = w_prod[31:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_done) begin
         if (!w_div_zero) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
      end else if ((r_state == c_idle) && bus.start) begin
         if (bus.op == c_op_mthi) r_hi <= bus.rs_val;
         if (bus.op == c_op_mtlo) r_lo <= bus.rs_val;
      end
   end
endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide responder for the EX stage of the 5-stage pipeline.
- EX issues a one-cycle start with an op and two operands. The unit asserts busy for a fixed number of cycles, then commits the result to its internal HI/LO registers.
- busy feeds the hazard unit, which stalls any md-class instruction (mult/div/mfhi/mflo/mthi/mtlo) while start or busy is high.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request strobe from EX
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6-7=reserved (no-op)
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- rt_val  input  32  forwarded rt operand (divisor / multiplier)
- busy  output  1  high while an operation is in flight
- hi  output  32  HI register, registered
- lo  output  32  LO register, registered

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately regardless of clk. Reset forces hi=0, lo=0, busy=0, state=IDLE, counter=0. Any in-flight operation is discarded and its result is never written.
- States: IDLE and RUN, plus a 4-bit down-counter cnt.
- IDLE with start=1 and op in {0,1,2,3}:
  - Latch rs_val, rt_val and op.
  - Load cnt = MULT_CYCLES-1 (ops 0,1) or DIV_CYCLES-1 (ops 2,3).
  - Go to RUN.
  - busy rises on the next cycle, i.e. it is registered.
- RUN:
  - busy=1 and cnt decrements each cycle.
  - On the edge where cnt==0 in RUN: write hi/lo, go to IDLE, busy=0.
  - busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - The new hi/lo values are visible in the first cycle busy is low.
- IDLE with start=1 and op=4: hi <= rs_val at that edge. busy stays 0; lo is unchanged.
- IDLE with start=1 and op=5: lo <= rs_val at that edge. busy stays 0; hi is unchanged.
- start=1 with op 6 or 7: ignored.
- start while in RUN (any op): ignored, including mthi/mtlo. The latched operation completes unaffected.
- Arithmetic, on the operands latched at start:
  - mult: {hi,lo} = signed(rs) * signed(rt), full 64-bit.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: lo = unsigned quotient; hi = unsigned remainder.
- Divide by zero (div or divu with rt=0): busy still runs the full DIV_CYCLES; hi and lo are left unchanged.
- Overflow case div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- Operand changes on rs_val/rt_val during RUN have no effect.
- Implementation freedom:
  - Either compute at latch time and hold the result until commit, or iterate.
  - Externally observable timing must match the above exactly.
  - hi/lo must not change before the commit edge.

Test Plan:
- Reset: assert reset mid-cycle while idle -> hi=0, lo=0, busy=0 immediately, without waiting for a clock edge.
- mult 0xFFFFFFFE × 0x00000003 (signed) -> busy high exactly 5 cycles starting the cycle after start; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div and divu:
  - div 0xFFFFFFF9 (-7) / 0x00000002 -> busy exactly 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - divu 7/2 -> lo=3, hi=1.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11111111 and lo=0x22222222 via mthi/mtlo, then div 5/0 -> busy for 10 cycles; hi and lo remain 0x11111111 and 0x22222222.
- Start and reset during RUN:
  - mult 3×4 started, then start with op=4 (rs_val=0xDEADBEEF) on cycle 2 of busy -> second request ignored; final hi=0, lo=12.
  - Separate run: reset asserted on cycle 3 of a div -> busy=0, hi=lo=0, and no later commit occurs.
